instr_encoder_loader: RTL and testbench
=======================================

Name: instr_encoder_loader

Overview:
Sequential program loader that packs decoded instruction fields into 16-bit instruction words and writes them into consecutive instruction-memory locations. It is the encoder counterpart of the instruction decoder: the bit layout per opcode class is identical, so a decode of any word it writes returns the original fields. It sits between the test/boot front end and instruction memory and streams one word per accepted field bundle.

Parameters:
BASE_ADDR, 6'd0, first instruction-memory address written after start
LAST_ADDR, 6'd63, last writable address; writing it ends the load

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-low
start  input  1  one-cycle pulse, begins a load session
in_valid  input  1  field bundle valid
in_ready  output  1  block can accept a bundle
opcode  input  5  instruction opcode
addressing_mode  input  1  0 = register form, 1 = memory form
rd  input  3  destination register
rs1  input  3  source register 1
rs2  input  3  source register 2
data_mem  input  4  data-memory address
instruction_mem  input  6  branch/jump target
s_r_amount  input  3  shift/rotate amount
imem_we  output  1  instruction-memory write strobe
imem_addr  output  6  write address
imem_wdata  output  16  encoded instruction word
count  output  7  words written this session, 0..64
busy  output  1  high in LOAD
done  output  1  high in DONE
err_illegal  output  1  sticky illegal-opcode flag

Behaviour:
- Reset (rst=0, async): state IDLE, wptr=BASE_ADDR; in_ready, imem_we, busy, done, err_illegal = 0; imem_addr=0, imem_wdata=0, count=0. Any write in flight is dropped.
- States: IDLE, LOAD, DONE, ERR.
- IDLE/DONE/ERR + start=1 -> LOAD; wptr=BASE_ADDR, count=0, done and err_illegal cleared. start is ignored in LOAD.
- in_ready = (state==LOAD). A bundle is accepted on a rising edge with in_valid & in_ready.
- Latency 1: a bundle accepted on edge N drives imem_we=1, imem_addr=wptr, imem_wdata=encoded word for the cycle after edge N. wptr++ and count++ on the same edge. imem_we is 0 in all other cycles. Back-to-back accepts give one write per cycle.
- Encoding: bit[15:11]=opcode, bit[10]=addressing_mode. Every bit not listed below is 0. Inputs not listed for a form are ignored.
  - MOVE 00000: mode0 rd[9:7] rs1[6:4]; mode1 rd[9:7] data_mem[6:3].
  - ADD/SUB/MUL/DIV/AND/OR/XOR 00001-00100, 00111, 01000, 01010, and COMPARE 11001: mode0 rd[9:7] rs1[6:4] rs2[3:1]; mode1 rd[9:7] rs1[6:4] data_mem[3:0].
  - INC/DEC/NOT 00101, 00110, 01001: mode0 rd[9:7]; mode1 data_mem[9:6].
  - LOAD 01011: rd[9:7] data_mem[6:3]. STORE 01100: data_mem[9:6] rd[5:3].
  - JUMP/BEQZ/BC/BAUX/BPAR 01101, 01110, 10110, 10111, 11000: instruction_mem[9:4].
  - ASHL..ROTR 10000-10101: mode0 rd[9:7] s_r_amount[6:4]; mode1 data_mem[9:6] s_r_amount[5:3].
  - HALT 11111: opcode and mode bit only.
- Illegal opcodes 11010-11110: on accept, no write, count unchanged, err_illegal=1, state -> ERR.
- Termination: accepting HALT, or accepting any legal bundle while wptr==LAST_ADDR, sets state -> DONE on the accept edge. The final write still occurs in the next cycle, with in_ready=0 in that cycle.
- wptr never wraps; a new session needs start.
- Reset mid-LOAD: immediate IDLE; the pending write is not issued.

Test Plan:
- Reset, start, ADD mode0 rd=3 rs1=1 rs2=2 -> one cycle later imem_we=1, addr=0, wdata=16'h0994, count=1.
- Back-to-back LOAD mode1 rd=5 dm=4'hA, then STORE mode0 dm=3 rd=6 -> writes 16'h5ED0 at 0 and 16'h60F0 at 1 on consecutive cycles.
- JUMP target 6'h2A, then HALT mode0 -> writes 16'h6AA0 and 16'hF800; in_ready drops the cycle after the HALT accept; done=1, count=2; further in_valid is ignored.
- Opcode 5'b11010 with in_valid -> no imem_we, err_illegal=1, state ERR; start clears err_illegal and loads again from address 0.
- BASE_ADDR=62, three legal bundles offered -> writes at 62 and 63, then DONE; third bundle not accepted; count=2.
- Assert rst low the cycle after an accept -> no write, all outputs 0, state IDLE.

Source files
------------

// File: rtl/instr_encoder_loader_if.sv
// Field-bundle handshake from the boot/test front end plus the instruction-memory
// write port produced by the loader.
interface instr_encoder_loader_if;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  opcode;
  logic        addressing_mode;
  logic [2:0]  rd;
  logic [2:0]  rs1;
  logic [2:0]  rs2;
  logic [3:0]  data_mem;
  logic [5:0]  instruction_mem;
  logic [2:0]  s_r_amount;
  logic        imem_we;
  logic [5:0]  imem_addr;
  logic [15:0] imem_wdata;

  modport master (
    output in_valid, opcode, addressing_mode, rd, rs1, rs2,
           data_mem, instruction_mem, s_r_amount,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, opcode, addressing_mode, rd, rs1, rs2,
           data_mem, instruction_mem, s_r_amount,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// Packs decoded instruction fields into 16-bit words and streams them into
// consecutive instruction-memory locations, one write per accepted bundle.
module instr_encoder_loader #(
  parameter logic [5:0] BASE_ADDR = 6'd0,
  parameter logic [5:0] LAST_ADDR = 6'd63
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  instr_encoder_loader_if.slave         bus,
  output logic [6:0]                    count,
  output logic                          busy,
  output logic                          done,
  output logic                          err_illegal
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE, ERR} state_t;

  typedef struct packed {
    logic [4:0] opcode;
    logic       mode;
    logic [2:0] rd;
    logic [2:0] rs1;
    logic [2:0] rs2;
    logic [3:0] dm;
    logic [5:0] im;
    logic [2:0] sa;
  } req_t;

  state_t      state, state_nxt;
  req_t        req;
  logic [5:0]  wptr;
  logic [15:0] enc;
  logic        accept, illegal, last;

  assign req = '{opcode: bus.opcode, mode: bus.addressing_mode, rd: bus.rd,
                 rs1: bus.rs1, rs2: bus.rs2, dm: bus.data_mem,
                 im: bus.instruction_mem, sa: bus.s_r_amount};

  assign bus.in_ready = (state == LOAD);
  assign busy         = (state == LOAD);
  assign done         = (state == DONE);
  assign accept       = bus.in_valid && (state == LOAD);
  assign illegal      = req.opcode inside {[5'd26:5'd30]};
  // HALT or the last slot closes the session; the final write still lands.
  assign last         = (req.opcode == 5'd31) || (wptr == LAST_ADDR);

  // Field placement mirrors the decoder so every written word round-trips.
  always_comb begin
    enc         = '0;
    enc[15:11]  = req.opcode;
    enc[10]     = req.mode;
    case (req.opcode) inside
      5'd0: begin
        enc[9:7] = req.rd;
        if (req.mode) enc[6:3] = req.dm;
        else          enc[6:4] = req.rs1;
      end
      5'd1, 5'd2, 5'd3, 5'd4, 5'd7, 5'd8, 5'd10, 5'd25: begin
        enc[9:7] = req.rd;
        enc[6:4] = req.rs1;
        if (req.mode) enc[3:0] = req.dm;
        else          enc[3:1] = req.rs2;
      end
      5'd5, 5'd6, 5'd9: begin
        if (req.mode) enc[9:6] = req.dm;
        else          enc[9:7] = req.rd;
      end
      5'd11: begin
        enc[9:7] = req.rd;
        enc[6:3] = req.dm;
      end
      5'd12: begin
        enc[9:6] = req.dm;
        enc[5:3] = req.rd;
      end
      5'd13, 5'd14, 5'd22, 5'd23, 5'd24: enc[9:4] = req.im;
      [5'd16:5'd21]: begin
        if (req.mode) begin
          enc[9:6] = req.dm;
          enc[5:3] = req.sa;
        end else begin
          enc[9:7] = req.rd;
          enc[6:4] = req.sa;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD: begin
        if (accept) begin
          if (illegal)   state_nxt = ERR;
          else if (last) state_nxt = DONE;
        end
      end
      default: if (start) state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr           <= BASE_ADDR;
      count          <= '0;
      err_illegal    <= 1'b0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
    end else begin
      bus.imem_we <= 1'b0;
      if (state != LOAD && start) begin
        wptr        <= BASE_ADDR;
        count       <= '0;
        err_illegal <= 1'b0;
      end
      if (accept) begin
        if (illegal) begin
          err_illegal <= 1'b1;
        end else begin
          bus.imem_we    <= 1'b1;
          bus.imem_addr  <= wptr;
          bus.imem_wdata <= enc;
          count          <= count + 7'd1;
          // Pointer parks at the last slot; only start rewinds it.
          if (wptr != LAST_ADDR) wptr <= wptr + 6'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench: driver pushes expected writes to per-DUT queues, negedge
// monitors pop and compare address, data and one-cycle latency.
module tb_instr_encoder_loader;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  logic        start0 = 1'b0, start1 = 1'b0;
  logic        v0 = 1'b0, v1 = 1'b0;
  logic [4:0]  f_op = '0;
  logic        f_m = 1'b0;
  logic [2:0]  f_rd = '0, f_rs1 = '0, f_rs2 = '0, f_sa = '0;
  logic [3:0]  f_dm = '0;
  logic [5:0]  f_im = '0;

  logic [6:0]  count0, count1;
  logic        busy0, busy1, done0, done1, err0, err1;

  instr_encoder_loader_if b0 ();
  instr_encoder_loader_if b1 ();

  assign b0.in_valid = v0;            assign b1.in_valid = v1;
  assign b0.opcode = f_op;            assign b1.opcode = f_op;
  assign b0.addressing_mode = f_m;    assign b1.addressing_mode = f_m;
  assign b0.rd = f_rd;                assign b1.rd = f_rd;
  assign b0.rs1 = f_rs1;              assign b1.rs1 = f_rs1;
  assign b0.rs2 = f_rs2;              assign b1.rs2 = f_rs2;
  assign b0.data_mem = f_dm;          assign b1.data_mem = f_dm;
  assign b0.instruction_mem = f_im;   assign b1.instruction_mem = f_im;
  assign b0.s_r_amount = f_sa;        assign b1.s_r_amount = f_sa;

  instr_encoder_loader #(.BASE_ADDR(6'd0), .LAST_ADDR(6'd63)) u0 (
    .clk(clk), .rst(rst), .start(start0), .bus(b0.slave),
    .count(count0), .busy(busy0), .done(done0), .err_illegal(err0));

  instr_encoder_loader #(.BASE_ADDR(6'd62), .LAST_ADDR(6'd63)) u1 (
    .clk(clk), .rst(rst), .start(start1), .bus(b1.slave),
    .count(count1), .busy(busy1), .done(done1), .err_illegal(err1));

  typedef struct {
    logic [5:0]  addr;
    logic [15:0] data;
    int          cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (b0.imem_we === 1'b1) begin
      if (q0.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL d0_unexpected_write: got addr %0h data %0h expected no write", b0.imem_addr, b0.imem_wdata);
      end else begin
        e0 = q0.pop_front();
        check("d0_addr", 32'(b0.imem_addr), 32'(e0.addr));
        check("d0_data", 32'(b0.imem_wdata), 32'(e0.data));
        check("d0_latency", 32'(cyc), 32'(e0.cyc));
      end
    end
  end

  always @(negedge clk) begin
    if (b1.imem_we === 1'b1) begin
      if (q1.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL d1_unexpected_write: got addr %0h data %0h expected no write", b1.imem_addr, b1.imem_wdata);
      end else begin
        e1 = q1.pop_front();
        check("d1_addr", 32'(b1.imem_addr), 32'(e1.addr));
        check("d1_data", 32'(b1.imem_wdata), 32'(e1.data));
        check("d1_latency", 32'(cyc), 32'(e1.cyc));
      end
    end
  end

  // Offer a bundle; wait up to 4 edges for acceptance. Returns right after the
  // accept edge (+1) so the next offer can follow back-to-back.
  task automatic offer(input int d, input logic [4:0] op, input logic m,
                       input logic [2:0] rd, input logic [2:0] rs1, input logic [2:0] rs2,
                       input logic [3:0] dm, input logic [5:0] im, input logic [2:0] sa,
                       input bit exp_acc, input bit wr, input logic [5:0] addr,
                       input logic [15:0] word);
    bit acc = 1'b0;
    logic rdy;
    exp_t e;
    f_op = op; f_m = m; f_rd = rd; f_rs1 = rs1; f_rs2 = rs2;
    f_dm = dm; f_im = im; f_sa = sa;
    if (d == 0) v0 = 1'b1; else v1 = 1'b1;
    for (int i = 0; i < 4 && !acc; i++) begin
      @(negedge clk);
      rdy = (d == 0) ? b0.in_ready : b1.in_ready;
      @(posedge clk);
      if (rdy) acc = 1'b1;
    end
    #1;
    v0 = 1'b0; v1 = 1'b0;
    check($sformatf("d%0d_accept_op%0h", d, op), 32'(acc), 32'(exp_acc));
    if (acc && wr) begin
      e.addr = addr; e.data = word; e.cyc = cyc;
      if (d == 0) q0.push_back(e); else q1.push_back(e);
    end
  endtask

  task automatic pulse_start(input int d);
    @(posedge clk); #1;
    if (d == 0) start0 = 1'b1; else start1 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0; start1 = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    check("rst_in_ready", 32'(b0.in_ready), 32'd0);
    check("rst_we", 32'(b0.imem_we), 32'd0);
    check("rst_addr", 32'(b0.imem_addr), 32'd0);
    check("rst_wdata", 32'(b0.imem_wdata), 32'd0);
    check("rst_count", 32'(count0), 32'd0);
    check("rst_flags", 32'({busy0, done0, err0}), 32'd0);
    @(posedge clk); #1 rst = 1'b1;

    pulse_start(0);
    check("load_busy", 32'(busy0), 32'd1);
    check("load_ready", 32'(b0.in_ready), 32'd1);
    check("load_count0", 32'(count0), 32'd0);

    // ADD mode0 rd=3 rs1=1 rs2=2
    offer(0, 5'd1, 1'b0, 3'd3, 3'd1, 3'd2, 4'h0, 6'h0, 3'd0, 1, 1, 6'd0, 16'h0994);
    check("count_after_add", 32'(count0), 32'd1);
    check("we_after_add", 32'(b0.imem_we), 32'd1);
    @(posedge clk); #1;
    // LOAD mode1 rd=5 dm=A, STORE mode0 dm=3 rd=6, back-to-back
    offer(0, 5'd11, 1'b1, 3'd5, 3'd0, 3'd0, 4'hA, 6'h0, 3'd0, 1, 1, 6'd1, 16'h5ED0);
    offer(0, 5'd12, 1'b0, 3'd6, 3'd0, 3'd0, 4'h3, 6'h0, 3'd0, 1, 1, 6'd2, 16'h60F0);
    // MOVE mode1, ASHL mode1, INC mode1, XOR mode1, COMPARE mode0
    offer(0, 5'd0,  1'b1, 3'd2, 3'd5, 3'd0, 4'h9, 6'h0, 3'd0, 1, 1, 6'd3, 16'h0548);
    offer(0, 5'd16, 1'b1, 3'd0, 3'd0, 3'd0, 4'h5, 6'h0, 3'd7, 1, 1, 6'd4, 16'h8578);
    offer(0, 5'd5,  1'b1, 3'd7, 3'd0, 3'd0, 4'hF, 6'h0, 3'd0, 1, 1, 6'd5, 16'h2FC0);
    offer(0, 5'd10, 1'b1, 3'd1, 3'd4, 3'd7, 4'h6, 6'h0, 3'd0, 1, 1, 6'd6, 16'h54C6);
    offer(0, 5'd25, 1'b0, 3'd7, 3'd7, 3'd7, 4'hF, 6'h3F, 3'd7, 1, 1, 6'd7, 16'hCBFE);
    // JUMP 2A, HALT mode0
    offer(0, 5'd13, 1'b0, 3'd7, 3'd7, 3'd7, 4'hF, 6'h2A, 3'd7, 1, 1, 6'd8, 16'h6AA0);
    offer(0, 5'd31, 1'b0, 3'd7, 3'd7, 3'd7, 4'hF, 6'h3F, 3'd7, 1, 1, 6'd9, 16'hF800);
    check("halt_ready_drop", 32'(b0.in_ready), 32'd0);
    check("halt_done", 32'(done0), 32'd1);
    check("halt_busy", 32'(busy0), 32'd0);
    check("halt_count", 32'(count0), 32'd10);
    offer(0, 5'd1, 1'b0, 3'd1, 3'd1, 3'd1, 4'h0, 6'h0, 3'd0, 0, 1, 6'd0, 16'h0);

    // Illegal opcode in a fresh session
    pulse_start(0);
    check("restart_done_clr", 32'(done0), 32'd0);
    check("restart_count", 32'(count0), 32'd0);
    offer(0, 5'd26, 1'b0, 3'd1, 3'd1, 3'd1, 4'h1, 6'h1, 3'd1, 1, 0, 6'd0, 16'h0);
    check("illegal_err", 32'(err0), 32'd1);
    check("illegal_ready", 32'(b0.in_ready), 32'd0);
    check("illegal_count", 32'(count0), 32'd0);
    @(posedge clk); #1;
    check("err_sticky", 32'(err0), 32'd1);
    pulse_start(0);
    check("err_cleared", 32'(err0), 32'd0);
    offer(0, 5'd1, 1'b0, 3'd3, 3'd1, 3'd2, 4'h0, 6'h0, 3'd0, 1, 1, 6'd0, 16'h0994);

    // Reset right after an accept drops the pending write
    offer(0, 5'd0, 1'b0, 3'd1, 3'd2, 3'd0, 4'h0, 6'h0, 3'd0, 1, 0, 6'd1, 16'h00A0);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_we", 32'(b0.imem_we), 32'd0);
    check("midrst_addr_data", 32'({b0.imem_addr, b0.imem_wdata}), 32'd0);
    check("midrst_count", 32'(count0), 32'd0);
    check("midrst_flags", 32'({b0.in_ready, busy0, done0, err0}), 32'd0);
    @(posedge clk); #1 rst = 1'b1;

    // Near-end base: slots 62 and 63 then DONE
    pulse_start(1);
    offer(1, 5'd1,  1'b0, 3'd3, 3'd1, 3'd2, 4'h0, 6'h0, 3'd0, 1, 1, 6'd62, 16'h0994);
    offer(1, 5'd11, 1'b1, 3'd5, 3'd0, 3'd0, 4'hA, 6'h0, 3'd0, 1, 1, 6'd63, 16'h5ED0);
    check("end_ready_drop", 32'(b1.in_ready), 32'd0);
    offer(1, 5'd12, 1'b0, 3'd6, 3'd0, 3'd0, 4'h3, 6'h0, 3'd0, 0, 1, 6'd0, 16'h0);
    check("end_done", 32'(done1), 32'd1);
    check("end_count", 32'(count1), 32'd2);

    repeat (3) @(posedge clk);
    #1;
    check("q0_drained", 32'(q0.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
